// File: rtl/edge_pe_neighbor_unpacker_pkg.sv
// -----------------------------------------------------------------------------
// edge_pe_neighbor_unpacker_pkg
//   Shared types for the edge-PE neighbor front end: the beat struct driven by
//   the neighbor bank controller, the stored FIFO entry, and the state enums of
//   the input tracker and the unpack FSM.
// -----------------------------------------------------------------------------
package edge_pe_neighbor_unpacker_pkg;

  // Bandwidth of one neighbor beat (two IDs), maximum degree and PE count.
  localparam int NEIGHBOR_INFO_BANDWIDTH = 32;
  localparam int MAX_DEGREE_ITER         = 64;
  localparam int NUM_EDGE_PE             = 4;

  localparam int NBR_CNT_W = $clog2(MAX_DEGREE_ITER) + 1;
  localparam int PE_TAG_W  = $clog2(NUM_EDGE_PE);

  // Beat from the neighbor bank controller (no backpressure).
  typedef struct packed {
    logic                               valid;
    logic                               sos;
    logic                               eos;
    logic [PE_TAG_W-1:0]                PE_tag;
    logic [NEIGHBOR_INFO_BANDWIDTH-1:0] FV_data;
    logic [NBR_CNT_W-1:0]               Neighbor_num_Iter;
  } Neighbor_bank_CNTL2Edge_PE;

  // Entry held in the beat FIFO.
  typedef struct packed {
    logic [NEIGHBOR_INFO_BANDWIDTH-1:0] fv_data;
    logic                               sos;
    logic                               eos;
    logic [NBR_CNT_W-1:0]               num_iter;
  } nbr_beat_t;

  localparam int NBR_BEAT_W = $bits(nbr_beat_t);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } nbr_unpack_state_t;

  typedef enum logic {
    TRK_CLOSED = 1'b0,
    TRK_OPEN   = 1'b1
  } nbr_trk_state_t;

endpackage

// File: rtl/edge_pe_neighbor_unpacker_nbr_beat_fifo.sv
// -----------------------------------------------------------------------------
// nbr_beat_fifo
//   Synchronous FIFO for neighbor beats. Head and the entry behind it are both
//   readable combinationally so the unpacker can move onto the next beat in the
//   same cycle it pops the current one. A push while full is accepted only when
//   a pop happens in the same cycle.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   push_i/data_i   write request and entry
//   pop_i           remove the head (ignored when empty)
//   head_o          current head entry
//   head_next_o     entry behind the head (valid when count_o >= 2)
//   full_o/empty_o  occupancy flags
//   count_o         number of stored entries
// -----------------------------------------------------------------------------
module nbr_beat_fifo #(
  parameter  int WIDTH = 41,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] head_next_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot the push lands in.
  assign push_ok = push_i && (!full_o || pop_ok);

  assign head_o      = mem_q[rd_ptr_q];
  assign head_next_o = mem_q[rd_ptr_q + AW'(1)];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; occupancy is tracked by the pointers and count,
  // so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/edge_pe_neighbor_unpacker.sv
// -----------------------------------------------------------------------------
// edge_pe_neighbor_unpacker
//   Edge-PE front end behind the neighbor bank controller. Beats tagged for this
//   PE are checked against the sos/eos framing, buffered, and unpacked into one
//   neighbor ID per cycle under valid/ready with first/last markers.
// Ports
//   clk, reset                       clock, asynchronous active-low reset
//   Neighbor_bank_CNTL2Edge_PE_in    incoming beat, no backpressure
//   nbr_valid/nbr_ready              output handshake
//   nbr_id, nbr_first, nbr_last      registered neighbor ID and stream markers
//   credit_ok                        FIFO can absorb a worst-case stream
//   overflow_err                     sticky: beat dropped on a full FIFO
//   proto_err                        sticky: sos/eos framing violated
// -----------------------------------------------------------------------------
module edge_pe_neighbor_unpacker
  import edge_pe_neighbor_unpacker_pkg::*;
#(
  parameter int PE_ID      = 0,
  parameter int NBR_ID_W   = 16,
  parameter int CNT_W      = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  Neighbor_bank_CNTL2Edge_PE Neighbor_bank_CNTL2Edge_PE_in,
  output logic                      nbr_valid,
  input  logic                      nbr_ready,
  output logic [NBR_ID_W-1:0]       nbr_id,
  output logic                      nbr_first,
  output logic                      nbr_last,
  output logic                      credit_ok,
  output logic                      overflow_err,
  output logic                      proto_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXB_C  = CW'(MAX_BEATS);

  Neighbor_bank_CNTL2Edge_PE in_beat;
  nbr_beat_t                 push_beat, head, head_nxt;
  logic [NBR_BEAT_W-1:0]     head_raw, head_nxt_raw;
  logic                      fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0]             fifo_count;

  nbr_trk_state_t    trk_q, trk_d;
  nbr_unpack_state_t state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d, rem_dec, rem_after;
  logic              valid_q, valid_d, first_q, first_d, last_q, last_d;
  logic [NBR_ID_W-1:0] id_q, id_d;
  logic              ovf_q, ovf_d, proto_q, proto_d;
  logic              mine, seq_bad, restart, push_req, hs, proto_unpack;
  logic              unused_nxt_eos;

  assign in_beat = Neighbor_bank_CNTL2Edge_PE_in;

  // ---------------- input tracker -------------------------------------------
  assign mine     = in_beat.valid && (in_beat.PE_tag == PE_TAG_W'(PE_ID));
  assign seq_bad  = mine && !in_beat.sos && (trk_q == TRK_CLOSED);
  assign restart  = mine && in_beat.sos && (trk_q == TRK_OPEN);
  assign push_req = mine && !seq_bad;

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    trk_d = trk_q;
    if (push_req) begin
      if (in_beat.eos)      trk_d = TRK_CLOSED;
      else if (in_beat.sos) trk_d = TRK_OPEN;
    end
  end

  assign push_beat = '{fv_data:  in_beat.FV_data,
                       sos:      in_beat.sos,
                       eos:      in_beat.eos,
                       num_iter: in_beat.Neighbor_num_Iter};
  assign fifo_push = push_req;

  nbr_beat_fifo #(
    .WIDTH (NBR_BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (fifo_push),
    .data_i      (push_beat),
    .pop_i       (fifo_pop),
    .head_o      (head_raw),
    .head_next_o (head_nxt_raw),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign head           = nbr_beat_t'(head_raw);
  assign head_nxt       = nbr_beat_t'(head_nxt_raw);
  assign unused_nxt_eos = head_nxt.eos;

  // ---------------- unpack FSM ----------------------------------------------
  assign hs      = valid_q && nbr_ready;
  assign rem_dec = (rem_q != '0) ? rem_q - CNT_W'(1) : rem_q;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    valid_d      = valid_q;
    id_d         = id_q;
    first_d      = first_q;
    last_d       = last_q;
    fifo_pop     = 1'b0;
    proto_unpack = 1'b0;
    rem_after    = rem_dec;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (head.sos) begin
            if (head.num_iter == '0) begin
              fifo_pop = 1'b1;              // empty stream: nothing to emit
            end else begin
              state_d = LO;
              rem_d   = head.num_iter;
              valid_d = 1'b1;
              id_d    = head.fv_data[NBR_ID_W-1:0];
              first_d = 1'b1;
              last_d  = (head.num_iter == CNT_W'(1));
            end
          end else if (rem_q == '0) begin
            fifo_pop = 1'b1;                // beat beyond the announced count
          end else begin
            state_d = LO;
            valid_d = 1'b1;
            id_d    = head.fv_data[NBR_ID_W-1:0];
            first_d = 1'b0;
            last_d  = (rem_q == CNT_W'(1));
          end
        end
      end

      LO: begin
        if (hs) begin
          rem_d = rem_dec;
          if (rem_dec == '0) begin
            fifo_pop = 1'b1;                // odd count: upper lane discarded
            state_d  = IDLE;
            valid_d  = 1'b0;
            first_d  = 1'b0;
            last_d   = 1'b0;
          end else begin
            state_d = HI;
            id_d    = head.fv_data[2*NBR_ID_W-1:NBR_ID_W];
            first_d = 1'b0;
            last_d  = (rem_dec == CNT_W'(1));
          end
        end
      end

      HI: begin
        if (hs) begin
          fifo_pop = 1'b1;
          // eos closes the stream even if IDs are still owed.
          if (head.eos && (rem_dec != '0)) begin
            proto_unpack = 1'b1;
            rem_after    = '0;
          end
          rem_d   = rem_after;
          state_d = IDLE;
          valid_d = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
          // Start the following beat directly to avoid a bubble.
          if (fifo_count >= CW'(2)) begin
            if (head_nxt.sos && (head_nxt.num_iter != '0)) begin
              state_d = LO;
              rem_d   = head_nxt.num_iter;
              valid_d = 1'b1;
              id_d    = head_nxt.fv_data[NBR_ID_W-1:0];
              first_d = 1'b1;
              last_d  = (head_nxt.num_iter == CNT_W'(1));
            end else if (!head_nxt.sos && (rem_after != '0)) begin
              state_d = LO;
              valid_d = 1'b1;
              id_d    = head_nxt.fv_data[NBR_ID_W-1:0];
              first_d = 1'b0;
              last_d  = (rem_after == CNT_W'(1));
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // ---------------- error flags ---------------------------------------------
  assign ovf_d   = ovf_q | (fifo_push && fifo_full && !fifo_pop);
  assign proto_d = proto_q | seq_bad | restart | proto_unpack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trk_q   <= TRK_CLOSED;
      state_q <= IDLE;
      rem_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      trk_q   <= trk_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      first_q <= first_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      proto_q <= proto_d;
    end
  end

  assign nbr_valid    = valid_q;
  assign nbr_id       = id_q;
  assign nbr_first    = first_q;
  assign nbr_last     = last_q;
  assign overflow_err = ovf_q;
  assign proto_err    = proto_q;
  assign credit_ok    = (DEPTH_C - fifo_count) >= MAXB_C;

endmodule

// File: tb/tb_edge_pe_neighbor_unpacker.sv
module tb_edge_pe_neighbor_unpacker;
  import edge_pe_neighbor_unpacker_pkg::*;

  localparam int MAXB = 5;
  localparam int MAXE = 6;
  localparam int NVEC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic nbr_ready = 1'b0;
  Neighbor_bank_CNTL2Edge_PE din = '0;
  logic nbr_valid, nbr_first, nbr_last, credit_ok, overflow_err, proto_err;
  logic [15:0] nbr_id;

  always #5 clk = ~clk;

  edge_pe_neighbor_unpacker #(
    .PE_ID(0), .NBR_ID_W(16), .CNT_W(7), .FIFO_DEPTH(8), .MAX_BEATS(4)
  ) u_dut (
    .clk                           (clk),
    .reset                         (rst_n),
    .Neighbor_bank_CNTL2Edge_PE_in (din),
    .nbr_valid                     (nbr_valid),
    .nbr_ready                     (nbr_ready),
    .nbr_id                        (nbr_id),
    .nbr_first                     (nbr_first),
    .nbr_last                      (nbr_last),
    .credit_ok                     (credit_ok),
    .overflow_err                  (overflow_err),
    .proto_err                     (proto_err)
  );

  typedef struct packed {
    logic [1:0]  tag;
    logic        sos;
    logic        eos;
    logic [6:0]  num;
    logic [31:0] data;
  } tb_beat_t;

  typedef struct packed {
    logic [15:0] id;
    logic        first;
    logic        last;
  } obs_t;

  typedef struct {
    string    name;
    int       nbeats;
    tb_beat_t beats [MAXB];
    bit       toggle;
    bit       chk_tp;
    logic     exp_proto;
    int       nexp;
    obs_t     exp [MAXE];
  } vec_t;

  vec_t vecs [NVEC];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int ready_mode = 2;   // 0: always ready, 1: toggle, 2: held low
  bit mon_en = 1'b0;
  int stall_bad = 0;
  bit prev_stall = 1'b0;
  logic [18:0] prev_out = '0;
  obs_t got [$];
  int   got_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       nbr_ready = 1'b1;
      1:       nbr_ready = ~nbr_ready;
      default: nbr_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (prev_stall && ({nbr_valid, nbr_id, nbr_first, nbr_last} !== prev_out))
        stall_bad++;
      prev_stall = nbr_valid && !nbr_ready;
      prev_out   = {nbr_valid, nbr_id, nbr_first, nbr_last};
      if (nbr_valid && nbr_ready) begin
        obs_t o;
        o.id = nbr_id; o.first = nbr_first; o.last = nbr_last;
        got.push_back(o);
        got_cyc.push_back(cyc);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic tb_beat_t bt(input logic [1:0] tag, input logic sos, input logic eos,
                                  input logic [6:0] num, input logic [31:0] data);
    tb_beat_t b;
    b.tag = tag; b.sos = sos; b.eos = eos; b.num = num; b.data = data;
    return b;
  endfunction

  function automatic obs_t ob(input logic [15:0] id, input logic first, input logic last);
    obs_t o;
    o.id = id; o.first = first; o.last = last;
    return o;
  endfunction

  // IDs 1..n with first on the first and last on the last.
  task automatic set_run(input int i, input int n);
    vecs[i].nexp = n;
    for (int k = 0; k < n; k++) vecs[i].exp[k] = ob(16'(k + 1), k == 0, k == n - 1);
  endtask

  task automatic send(input tb_beat_t b);
    din.valid = 1'b1; din.sos = b.sos; din.eos = b.eos; din.PE_tag = b.tag;
    din.FV_data = b.data; din.Neighbor_num_Iter = b.num;
    @(posedge clk); #1;
    din.valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".valid"}, 32'(nbr_valid), 32'd0);
    check({tag, ".id"},    32'(nbr_id),    32'd0);
    check({tag, ".first"}, 32'(nbr_first), 32'd0);
    check({tag, ".last"},  32'(nbr_last),  32'd0);
    check({tag, ".credit"}, 32'(credit_ok), 32'd1);
    check({tag, ".ovf"},   32'(overflow_err), 32'd0);
    check({tag, ".proto"}, 32'(proto_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- vector table -----------------------------------------
    for (int i = 0; i < NVEC; i++) begin
      vecs[i].nbeats = 0; vecs[i].toggle = 0; vecs[i].chk_tp = 0;
      vecs[i].exp_proto = 1'b0; vecs[i].nexp = 0;
    end
    vecs[0].name = "single_odd"; vecs[0].nbeats = 1; vecs[0].chk_tp = 1;
    vecs[0].beats[0] = bt(0, 1, 1, 1, 32'h0002_0001);
    set_run(0, 1);

    for (int i = 1; i <= 2; i++) begin
      vecs[i].nbeats = 3;
      vecs[i].beats[0] = bt(0, 1, 0, 5, 32'h0002_0001);
      vecs[i].beats[1] = bt(0, 0, 0, 5, 32'h0004_0003);
      vecs[i].beats[2] = bt(0, 0, 1, 5, 32'h0006_0005);
      set_run(i, 5);
    end
    vecs[1].name = "five_ready";  vecs[1].chk_tp = 1;
    vecs[2].name = "five_toggle"; vecs[2].toggle = 1;

    vecs[3].name = "two_lane"; vecs[3].nbeats = 1; vecs[3].chk_tp = 1; vecs[3].nexp = 2;
    vecs[3].beats[0] = bt(0, 1, 1, 2, 32'hBBBB_AAAA);
    vecs[3].exp[0] = ob(16'hAAAA, 1, 0);
    vecs[3].exp[1] = ob(16'hBBBB, 0, 1);

    vecs[4].name = "four_even"; vecs[4].nbeats = 2; vecs[4].chk_tp = 1;
    vecs[4].beats[0] = bt(0, 1, 0, 4, 32'h0002_0001);
    vecs[4].beats[1] = bt(0, 0, 1, 4, 32'h0004_0003);
    set_run(4, 4);

    vecs[5].name = "three_odd"; vecs[5].nbeats = 2; vecs[5].chk_tp = 1; vecs[5].nexp = 3;
    vecs[5].beats[0] = bt(0, 1, 0, 3, 32'h0012_0011);
    vecs[5].beats[1] = bt(0, 0, 1, 3, 32'h0014_0013);
    vecs[5].exp[0] = ob(16'h0011, 1, 0);
    vecs[5].exp[1] = ob(16'h0012, 0, 0);
    vecs[5].exp[2] = ob(16'h0013, 0, 1);

    vecs[6].name = "foreign_mix"; vecs[6].nbeats = 5;
    vecs[6].beats[0] = bt(0, 1, 0, 5, 32'h0002_0001);
    vecs[6].beats[1] = bt(1, 1, 1, 2, 32'hDEAD_BEEF);
    vecs[6].beats[2] = bt(0, 0, 0, 5, 32'h0004_0003);
    vecs[6].beats[3] = bt(2, 1, 0, 3, 32'h7777_6666);
    vecs[6].beats[4] = bt(0, 0, 1, 5, 32'h0006_0005);
    set_run(6, 5);

    vecs[7].name = "eos_early"; vecs[7].nbeats = 1; vecs[7].exp_proto = 1'b1; vecs[7].nexp = 2;
    vecs[7].beats[0] = bt(0, 1, 1, 5, 32'h0002_0001);
    vecs[7].exp[0] = ob(16'h0001, 1, 0);
    vecs[7].exp[1] = ob(16'h0002, 0, 0);

    vecs[8].name = "zero_num"; vecs[8].nbeats = 2; vecs[8].nexp = 1;
    vecs[8].beats[0] = bt(0, 1, 1, 0, 32'h0000_0077);
    vecs[8].beats[1] = bt(0, 1, 1, 1, 32'h0000_0042);
    vecs[8].exp[0] = ob(16'h0042, 1, 1);

    vecs[9].name = "sos_restart"; vecs[9].nbeats = 2; vecs[9].exp_proto = 1'b1; vecs[9].nexp = 3;
    vecs[9].beats[0] = bt(0, 1, 0, 2, 32'h0002_0001);
    vecs[9].beats[1] = bt(0, 1, 1, 1, 32'h0000_0009);
    vecs[9].exp[0] = ob(16'h0001, 1, 0);
    vecs[9].exp[1] = ob(16'h0002, 0, 1);
    vecs[9].exp[2] = ob(16'h0009, 1, 1);

    // ---------------- reset state ------------------------------------------
    @(posedge clk); #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // ---------------- table-driven streams ---------------------------------
    for (int i = 0; i < NVEC; i++) begin
      int base, sbase, w;
      ready_mode = vecs[i].toggle ? 1 : 0;
      do_reset();
      base  = got.size();
      sbase = stall_bad;
      for (int b = 0; b < vecs[i].nbeats; b++) send(vecs[i].beats[b]);
      w = 0;
      while ((got.size() - base) < vecs[i].nexp && w < 200) begin
        @(posedge clk); #1;
        w++;
      end
      repeat (6) @(posedge clk);
      #1;
      check($sformatf("%s.count", vecs[i].name), 32'(got.size() - base), 32'(vecs[i].nexp));
      for (int j = 0; j < vecs[i].nexp; j++) begin
        logic [31:0] act;
        act = (base + j < got.size()) ? 32'(got[base + j]) : 32'hFFFF_FFFF;
        check($sformatf("%s.id%0d", vecs[i].name, j), act, 32'(vecs[i].exp[j]));
      end
      if (vecs[i].chk_tp && (got.size() - base) == vecs[i].nexp)
        check($sformatf("%s.throughput", vecs[i].name),
              32'(got_cyc[got.size() - 1] - got_cyc[base]), 32'(vecs[i].nexp - 1));
      if (vecs[i].toggle)
        check($sformatf("%s.stall_stable", vecs[i].name), 32'(stall_bad - sbase), 32'd0);
      check($sformatf("%s.proto", vecs[i].name), 32'(proto_err), 32'(vecs[i].exp_proto));
      check($sformatf("%s.ovf", vecs[i].name), 32'(overflow_err), 32'd0);
    end

    // ---------------- credit and overflow with output stalled --------------
    ready_mode = 2;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      int occ;
      send(bt(0, 1, 1, 2, {16'(k + 16), 16'(k)}));
      occ = (k > 8) ? 8 : k;
      check($sformatf("fill%0d.credit", k), 32'(credit_ok), 32'((8 - occ) >= 4));
      check($sformatf("fill%0d.ovf", k), 32'(overflow_err), 32'(k == 9));
    end
    check("fill.valid", 32'(nbr_valid), 32'd1);
    check("fill.id", 32'(nbr_id), 32'h0001);
    check("fill.first_last", {30'd0, nbr_first, nbr_last}, 32'b10);
    check("fill.proto", 32'(proto_err), 32'd0);

    // ---------------- non-sos beat while closed ----------------------------
    ready_mode = 0;
    do_reset();
    begin
      int base;
      base = got.size();
      send(bt(0, 0, 0, 3, 32'h0002_0001));
      repeat (4) @(posedge clk);
      #1;
      check("nosos.proto", 32'(proto_err), 32'd1);
      check("nosos.valid", 32'(nbr_valid), 32'd0);
      check("nosos.count", 32'(got.size() - base), 32'd0);
    end

    // ---------------- reset asserted mid-stream ----------------------------
    ready_mode = 2;
    do_reset();
    send(bt(0, 1, 0, 5, 32'h0002_0001));
    repeat (2) @(posedge clk);
    #1;
    check("mid.valid_before", 32'(nbr_valid), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
